// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one decryption round per clock,
// valid/ready handshakes on ciphertext input and plaintext output.

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Table is stored byte 0 first, so invert the index for the slice.
    assign y = INV_SBOX[{~a, 3'b000} +: 8];

endmodule

module aes_inv_cipher_iter #(
    parameter int NR    = 10,
    parameter int KEY_W = 128 * (NR + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     ct,
    input  logic [KEY_W-1:0] round_keys,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     pt,
    output logic             busy,
    output logic [3:0]       round_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } fsm_t;

    fsm_t         fsm;
    logic [127:0] st;
    logic [127:0] rk_cur;
    logic [127:0] sr;
    logic [127:0] sb;
    logic [127:0] ark;
    logic [127:0] imc;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] x);
        return xt(xt(xt(x))) ^ x;
    endfunction

    function automatic logic [7:0] gmb(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(x) ^ x;
    endfunction

    function automatic logic [7:0] gmd(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
    endfunction

    function automatic logic [7:0] gme(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
    endfunction

    // Byte (row r, column c) lives at index r + 4*c, byte 0 at the MSB.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gme(a0) ^ gmb(a1) ^ gmd(a2) ^ gm9(a3);
            o[119-32*c -: 8] = gm9(a0) ^ gme(a1) ^ gmb(a2) ^ gmd(a3);
            o[111-32*c -: 8] = gmd(a0) ^ gm9(a1) ^ gme(a2) ^ gmb(a3);
            o[103-32*c -: 8] = gmb(a0) ^ gmd(a1) ^ gm9(a2) ^ gme(a3);
        end
        return o;
    endfunction

    always_comb begin
        rk_cur = '0;
        for (int r = 0; r <= NR; r++) begin
            if (round_cnt == 4'(r)) begin
                rk_cur = round_keys[KEY_W-1-128*r -: 128];
            end
        end
    end

    assign sr = inv_shift_rows(st);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .a (sr[127-8*i -: 8]),
            .y (sb[127-8*i -: 8])
        );
    end

    // In FINAL round_cnt is 0, so the same key-add yields the plaintext.
    assign ark = sb ^ rk_cur;
    assign imc = inv_mix_columns(ark);

    assign in_ready = rst && (fsm == S_IDLE);
    assign busy     = (fsm == S_ROUND) || (fsm == S_FINAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= S_IDLE;
            st        <= '0;
            pt        <= '0;
            out_valid <= 1'b0;
            round_cnt <= '0;
        end else begin
            unique case (fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        st        <= ct ^ round_keys[127:0];
                        round_cnt <= 4'(NR - 1);
                        fsm       <= (NR == 1) ? S_FINAL : S_ROUND;
                    end
                end
                S_ROUND: begin
                    st <= imc;
                    if (round_cnt == 4'd1) begin
                        round_cnt <= '0;
                        fsm       <= S_FINAL;
                    end else if (round_cnt != 4'd0) begin
                        round_cnt <= round_cnt - 4'd1;
                    end
                end
                S_FINAL: begin
                    pt        <= ark;
                    out_valid <= 1'b1;
                    fsm       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES inverse-cipher core: one round per clock, with valid/ready handshakes on both input and output.
- Takes a 128-bit ciphertext block and the fully expanded key schedule from the key-expansion block, and returns the plaintext.
- Sits downstream of the encryption datapath, or of any ciphertext source. Replaces the fully-unrolled counter-driven decryption with a shared-round, back-pressured core.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256).
- KEY_W, 128*(NR+1), width of the expanded key bus.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  ciphertext offered.
- in_ready  out  1  core can accept; high only in IDLE.
- ct  in  128  ciphertext, byte 0 at [127:120].
- round_keys  in  KEY_W  expanded key. Round key r is at [KEY_W-1-128*r -: 128]; r=0 is the cipher key.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer takes plaintext.
- pt  out  128  plaintext, registered.
- busy  out  1  high in ROUND or FINAL.
- round_cnt  out  4  current round index, for debug.

Behaviour:
- Reset (rst=0, async): state=IDLE, pt=0, out_valid=0, busy=0, round_cnt=0. in_ready is 0 while rst=0.
- States: IDLE, ROUND, FINAL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at an edge:
  - state_reg <= ct ^ rk[NR]
  - round_cnt <= NR-1
  - go to ROUND (go to FINAL if NR-1==0; not used for legal NR).
- ROUND, one cycle per round:
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk[round_cnt]).
  - If round_cnt==1, go to FINAL with round_cnt <= 0; otherwise round_cnt decrements.
- FINAL:
  - pt <= InvSubBytes(InvShiftRows(state_reg)) ^ rk[0].
  - out_valid <= 1; go to DONE.
- DONE:
  - pt and out_valid are held stable.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
  - New input is not accepted in the same cycle.
- Latency: out_valid rises exactly NR clock edges after the accept edge (10/12/14). Minimum initiation interval is NR+2 cycles.
- round_keys is not registered. The source must hold it stable from the accept edge until out_valid. ct is sampled only at the accept edge.
- in_valid while not in IDLE is ignored; no data is captured.
- out_ready while out_valid=0 has no effect.
- InvSubBytes uses 16 instances of the team's inverse S-box byte lookup.
- InvMixColumns is combinational GF(2^8) multiply by 0e/0b/0d/09 via xtime chains.
- InvShiftRows rotates row i right by i bytes, in column-major state order.
- rk index arithmetic is 4-bit. round_cnt never wraps below 0.
- Reset mid-operation aborts immediately; all outputs return to their reset values. The first transaction after rst rises is processed normally.
- The pt register changes only in FINAL; between transactions it retains the last plaintext.

Test Plan:
- NR=10: round_keys from key-expansion with key 000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> out_valid at accept+10 edges, pt=00112233445566778899aabbccddeeff.
- NR=12: key 000102…1617, ct=dda97ca4864cdfe06eaf70a0ec0d7191 -> pt=00112233445566778899aabbccddeeff at accept+12 edges.
- NR=14: key 000102…1e1f, ct=8ea2b7ca516745bfeafc49904b496089 -> pt=00112233445566778899aabbccddeeff at accept+14 edges.
- Back-pressure (NR=10): hold out_ready=0 for 5 cycles after out_valid -> pt and out_valid stable and in_ready=0 throughout. One cycle after the out_ready handshake, in_ready=1.
- in_valid pulsed with junk ct during ROUND -> ignored; pt is still the correct C.1 plaintext.
- Assert rst=0 asynchronously mid-ROUND (round_cnt=5), release, then resend C.1 -> outputs zero during reset; correct pt after exactly 10 edges.
